// File: rtl/mma_pkg.sv
// mma_pkg: shared types and constants for the matrix-multiply job sequencer.
package mma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        CMP_ISSUE,
        CMP_WAIT,
        WB_ISSUE,
        WB_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK,
        ERR_BAD_TYPE,
        ERR_TIMEOUT,
        ERR_ABORT
    } err_t;

    localparam logic [1:0] TYPE_M8K16N32  = 2'd0;
    localparam logic [1:0] TYPE_M16K16N16 = 2'd1;
    localparam logic [1:0] TYPE_M32K16N8  = 2'd2;
    localparam logic [1:0] TYPE_ILLEGAL   = 2'd3;

    // Block dimensions indexed by matrix type; the illegal slot is zero.
    localparam int M_DIM [4] = '{8, 16, 32, 0};
    localparam int K_DIM [4] = '{16, 16, 16, 0};
    localparam int N_DIM [4] = '{32, 16, 8, 0};

    typedef struct packed {
        logic [1:0] mtype;
        logic [5:0] mul;
        logic [5:0] add;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic type_legal(input logic [1:0] t);
        return t != TYPE_ILLEGAL;
    endfunction

endpackage

// File: rtl/mma_cmd_slot.sv
// mma_cmd_slot: one-entry valid/ready command buffer, emptied by the sequencer's pop.
module mma_cmd_slot
    import mma_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] in_data,
    input  logic             pop,
    output logic             full,
    output logic [CMD_W-1:0] out_data
);

    logic accept;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full     <= 1'b0;
            out_data <= '0;
        end else begin
            full <= accept || (full && !pop);
            if (accept) out_data <= in_data;
        end
    end

endmodule

// File: rtl/mma_job_ctrl.sv
// mma_job_ctrl: job-level sequencer for the blocked matrix-multiply engine.
// Runs load, NBLK compute passes and writeback per command, with a per-wait watchdog and abort.
module mma_job_ctrl
    import mma_pkg::*;
#(
    parameter int  NBLK    = 4,
    parameter int  TIMEOUT = 4096,
    parameter int  WD_W    = 16,
    localparam int BW      = (NBLK > 1) ? $clog2(NBLK) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_type,
    input  logic [5:0]    cmd_mul_prec,
    input  logic [5:0]    cmd_add_prec,
    input  logic          abort,
    output logic [1:0]    cfg_type,
    output logic [5:0]    cfg_mul_valid,
    output logic [5:0]    cfg_add_valid,
    output logic          read_start,
    input  logic          read_done,
    output logic          cmp_start,
    output logic [BW-1:0] cmp_blk,
    input  logic          cmp_done,
    output logic          wb_start,
    input  logic          wb_done,
    output logic          busy,
    output logic          job_done,
    output logic [1:0]    job_err,
    output logic [31:0]   job_cycles
);

    state_t           state, nxt;
    err_t             err_nxt;
    logic             slot_full, pop, legal, wait_st, done_in, tmo, last;
    logic [CMD_W-1:0] slot_data;
    cmd_t             slot_cmd;
    logic [WD_W-1:0]  wd;
    logic [31:0]      cnt;

    mma_cmd_slot u_slot (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (cmd_valid),
        .in_ready (cmd_ready),
        .in_data  ({cmd_type, cmd_mul_prec, cmd_add_prec}),
        .pop      (pop),
        .full     (slot_full),
        .out_data (slot_data)
    );

    assign slot_cmd   = cmd_t'(slot_data);
    assign legal      = type_legal(slot_cmd.mtype);
    assign pop        = state == IDLE && slot_full;
    assign last       = cmp_blk == BW'(NBLK - 1);
    assign wait_st    = state inside {RD_WAIT, CMP_WAIT, WB_WAIT};
    assign done_in    = (state == RD_WAIT && read_done) || (state == CMP_WAIT && cmp_done) ||
                        (state == WB_WAIT && wb_done);
    assign tmo        = wd == WD_W'(TIMEOUT - 1);
    assign busy       = state != IDLE;
    assign read_start = state == RD_ISSUE;
    assign cmp_start  = state == CMP_ISSUE;
    assign wb_start   = state == WB_ISSUE;
    assign job_done   = state == DONE;

    always_comb begin
        nxt     = state;
        err_nxt = ERR_OK;
        case (state)
            IDLE: begin
                if (slot_full) begin
                    nxt     = legal ? RD_ISSUE : DONE;
                    err_nxt = legal ? ERR_OK : ERR_BAD_TYPE;
                end
            end
            RD_ISSUE:  nxt = RD_WAIT;
            RD_WAIT:   nxt = done_in ? CMP_ISSUE : RD_WAIT;
            CMP_ISSUE: nxt = CMP_WAIT;
            CMP_WAIT:  nxt = done_in ? (last ? WB_ISSUE : CMP_ISSUE) : CMP_WAIT;
            WB_ISSUE:  nxt = WB_WAIT;
            WB_WAIT:   nxt = done_in ? DONE : WB_WAIT;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        // A done in the last watchdog cycle wins over the timeout; abort wins over both.
        if (wait_st && !done_in && tmo) begin
            nxt     = DONE;
            err_nxt = ERR_TIMEOUT;
        end
        if (abort && state != IDLE && state != DONE) begin
            nxt     = DONE;
            err_nxt = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cfg_type      <= '0;
            cfg_mul_valid <= '0;
            cfg_add_valid <= '0;
            cmp_blk       <= '0;
            job_err       <= '0;
            job_cycles    <= '0;
            wd            <= '0;
            cnt           <= '0;
        end else begin
            state <= nxt;
            wd    <= wait_st ? wd + WD_W'(1) : '0;
            if (nxt == RD_ISSUE) begin
                cfg_type      <= slot_cmd.mtype;
                cfg_mul_valid <= slot_cmd.mul;
                cfg_add_valid <= slot_cmd.add;
                cmp_blk       <= '0;
                cnt           <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 32'd1;
            end
            if (state == CMP_WAIT && nxt == CMP_ISSUE) cmp_blk <= cmp_blk + BW'(1);
            // cnt lags the DONE cycle by one and excludes the RD_ISSUE cycle, hence +2.
            if (nxt == DONE) begin
                job_err    <= err_nxt;
                job_cycles <= (state == IDLE) ? '0 : (cnt > 32'hFFFF_FFFD ? '1 : cnt + 32'd2);
            end
        end
    end

endmodule
